pipo_univ_shreg: RTL and testbench
==================================

PIPO_UNIV_SHREG -- requirements
Module: pipo_univ_shreg

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits; SHALL be a power of 2, >= 4.
REQ-002 Parameter STEP, default 1: maximum bit positions shifted per clock; SHALL satisfy 1 <= STEP <= WIDTH/2.
REQ-003 Derived constant AW = $clog2(WIDTH): width of the shift-amount port.
REQ-004 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 LOAD  input  1  synchronous parallel load strobe.
REQ-007 START  input  1  begins a multi-cycle shift operation.
REQ-008 MODE  input  2  00 rotate right, 01 rotate left, 10 shift right, 11 logical shift left (zero fill).
REQ-009 AMT  input  AW  total shift distance, 0..WIDTH-1.
REQ-010 Din  input  WIDTH  parallel load data.
REQ-011 Dout  output  WIDTH  registered register contents.
REQ-012 BUSY  output  1  high while a shift operation is in progress.
REQ-013 DONE  output  1  one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have two states, IDLE and RUN.
REQ-015 LOAD SHALL have priority over START in every state: Dout <= Din, next state IDLE, the remaining count cleared, DONE=0 that cycle.
REQ-016 LOAD in RUN SHALL abort the operation: BUSY falls the next cycle and no DONE is issued.
REQ-017 START in IDLE with LOAD=0 and AMT != 0 SHALL capture MODE and AMT, set remaining=AMT, and enter RUN.
REQ-018 START in IDLE with AMT=0 SHALL leave Dout unchanged, stay in IDLE, and pulse DONE for one cycle.
REQ-019 START in RUN SHALL be ignored; MODE and AMT changes during RUN SHALL have no effect.
REQ-020 Each RUN cycle SHALL shift Dout by k = min(STEP, remaining) in the captured mode and decrement remaining by k.
REQ-021 When remaining reaches 0, the FSM SHALL return to IDLE; BUSY falls and DONE is high for exactly that one cycle.
REQ-022 The operation SHALL take ceil(AMT/STEP) RUN cycles, with BUSY high for exactly those cycles.
REQ-023 Rotate modes SHALL wrap bits end-around with no loss; the shift result after AMT total bits SHALL equal a single-step shift by AMT.
REQ-024 In IDLE with no LOAD or START, Dout SHALL hold.

Reset
REQ-025 RST high SHALL immediately force Dout=0, BUSY=0, DONE=0, state IDLE, remaining=0, and captured mode=00, regardless of CLK.
REQ-026 RST during RUN SHALL abandon the operation without any DONE pulse.
REQ-027 The first rising edge after RST deasserts SHALL be treated as an ordinary IDLE cycle.

Configuration
REQ-028 Macro PIPO_ARITH_SHIFT_EN, when defined: MODE 10 SHALL be an arithmetic right shift, replicating Dout[WIDTH-1] into vacated bits.
REQ-029 When PIPO_ARITH_SHIFT_EN is undefined: MODE 10 SHALL be a logical right shift with zero fill, and no sign-replication logic SHALL be synthesised.

Structure
REQ-030 Shared package pipo_shreg_pkg SHALL hold the MODE encoding typedef, the FSM state typedef, and the ceil-divide helper function.
REQ-031 One combinational sub-module, pipo_shift_step, SHALL compute the shift of a WIDTH vector by a k in 0..STEP for a given mode; the top module instantiates it once.

Verification
REQ-032 Rotate right: WIDTH=8, STEP=1; LOAD Din=0xB1, then START MODE=00, AMT=3 -> BUSY high 3 cycles, Dout=0x36, DONE one cycle.
REQ-033 Rotate left: LOAD 0x81, START MODE=01, AMT=1 -> Dout=0x03 after 1 cycle; DONE coincides with BUSY fall.
REQ-034 Right shift: LOAD 0xF0, START MODE=10, AMT=4 -> Dout=0xFF with PIPO_ARITH_SHIFT_EN defined, Dout=0x0F without it.
REQ-035 Multi-step: STEP=2; LOAD 0x01, START MODE=11, AMT=5 -> 3 RUN cycles with intermediate values 0x04, 0x10, then final 0x20.
REQ-036 Abort and edge cases, each checked:
- LOAD 0x55 in the second RUN cycle of an AMT=6 operation -> Dout=0x55, no DONE.
- START with AMT=0 -> DONE next cycle, BUSY never high.
- RST mid-RUN -> Dout=0x00 immediately.

Source files
------------

// File: rtl/pipo_shreg_pkg.sv
// Shared definitions for the universal PIPO shift register: shift mode
// encoding, FSM state encoding and a ceil-divide helper for run-length math.
package pipo_shreg_pkg;

  // MODE port encoding
  typedef enum logic [1:0] {
    MODE_ROR = 2'b00,  // rotate right
    MODE_ROL = 2'b01,  // rotate left
    MODE_SHR = 2'b10,  // shift right (logical, or arithmetic when enabled)
    MODE_SHL = 2'b11   // logical shift left, zero fill
  } shift_mode_e;

  // Operation FSM states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } shreg_state_e;

  // Number of STEP-sized chunks needed to cover num bit positions
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/pipo_shift_step.sv
// Combinational single-step shifter: moves a WIDTH-bit vector by k positions
// (0..STEP) in the requested mode. Every fixed distance is built from constant
// slices and the live one is selected by k, so no barrel shifter wider than
// STEP positions is generated.
// Macro PIPO_ARITH_SHIFT_EN: when defined, MODE_SHR replicates the MSB into
// vacated bits; otherwise it zero-fills.
module pipo_shift_step
  import pipo_shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [KW-1:0]    k,
  input  shift_mode_e      mode,
  output logic [WIDTH-1:0] result
);

  // Doubled copy makes every rotate a plain window into the vector
  logic [2*WIDTH-1:0] dbl;
  assign dbl = {data, data};

  logic [WIDTH-1:0] ror_c [STEP+1];
  logic [WIDTH-1:0] rol_c [STEP+1];
  logic [WIDTH-1:0] shr_c [STEP+1];
  logic [WIDTH-1:0] shl_c [STEP+1];

  genvar gi;
  generate
    for (gi = 0; gi <= STEP; gi++) begin : g_amt
      assign ror_c[gi] = dbl[gi +: WIDTH];
      assign rol_c[gi] = dbl[WIDTH-gi +: WIDTH];
`ifdef PIPO_ARITH_SHIFT_EN
      assign shr_c[gi] = WIDTH'($signed(data) >>> gi);
`else
      assign shr_c[gi] = data >> gi;
`endif
      assign shl_c[gi] = data << gi;
    end
  endgenerate

  // Pick the candidate for the live distance and mode; k=0 passes data through
  always_comb begin
    result = data;
    for (int i = 0; i <= STEP; i++) begin
      if (k == KW'(i)) begin
        case (mode)
          MODE_ROR: result = ror_c[i];
          MODE_ROL: result = rol_c[i];
          MODE_SHR: result = shr_c[i];
          MODE_SHL: result = shl_c[i];
          default:  result = data;
        endcase
      end
    end
  end

endmodule

// File: rtl/pipo_univ_shreg.sv
// Universal parallel-in/parallel-out shift register. A START launches a
// multi-cycle operation that moves the register by up to STEP bits per clock
// until AMT bits have been covered; LOAD always wins and aborts any operation.
// Macro PIPO_ARITH_SHIFT_EN: when defined, MODE 10 is an arithmetic right
// shift; otherwise it is a logical right shift.
module pipo_univ_shreg
  import pipo_shreg_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int STEP  = 1,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic             START,
  input  logic [1:0]       MODE,
  input  logic [AW-1:0]    AMT,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout,
  output logic             BUSY,
  output logic             DONE
);

  localparam int KW = $clog2(STEP + 1);

  shreg_state_e     state_reg;
  shift_mode_e      mode_reg;
  logic [AW-1:0]    rem_reg;
  logic [WIDTH-1:0] dout_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [KW-1:0]    k_step;
  logic [AW-1:0]    rem_next;
  logic [WIDTH-1:0] shifted;

  // Distance for this cycle is min(STEP, remaining); remaining is 0 in IDLE
  always_comb begin
    k_step   = (rem_reg > AW'(STEP)) ? KW'(STEP) : KW'(rem_reg);
    rem_next = rem_reg - AW'(k_step);
  end

  pipo_shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .data   (dout_reg),
    .k      (k_step),
    .mode   (mode_reg),
    .result (shifted)
  );

  // Operation FSM with registered data, BUSY and DONE
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      mode_reg  <= MODE_ROR;
      rem_reg   <= '0;
      dout_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (LOAD) begin
        dout_reg  <= Din;
        state_reg <= ST_IDLE;
        rem_reg   <= '0;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (START) begin
              if (AMT == '0) begin
                done_reg <= 1'b1;
              end else begin
                mode_reg  <= shift_mode_e'(MODE);
                rem_reg   <= AMT;
                state_reg <= ST_RUN;
                busy_reg  <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            dout_reg <= shifted;
            rem_reg  <= rem_next;
            if (rem_next == '0) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Dout = dout_reg;
  assign BUSY = busy_reg;
  assign DONE = done_reg;

endmodule

// File: tb/tb_pipo_univ_shreg.sv
// Testbench for pipo_univ_shreg: two instances (STEP=1 and STEP=2, WIDTH=8)
// share one stimulus stream and are compared every cycle against an
// operation-level reference model, plus directed scenario checks.
module tb_pipo_univ_shreg;

  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic       load;
  logic       start;
  logic [1:0] mode;
  logic [2:0] amt;
  logic [7:0] din;

  logic [7:0] dout_w [2];
  logic       busy_w [2];
  logic       done_w [2];

  int n_checks;
  int n_pass;

  // reference model state, one per instance
  logic [7:0] m_dout [2];
  bit         m_busy [2];
  bit         m_done [2];
  logic [1:0] m_mode [2];
  logic [7:0] m_base [2];
  int         m_amt  [2];
  int         m_el   [2];

  int cnt_busy [2];
  int cnt_done [2];

  pipo_univ_shreg #(.WIDTH(W), .STEP(1)) dut_s1 (
    .CLK (clk), .RST (rst), .LOAD (load), .START (start), .MODE (mode),
    .AMT (amt), .Din (din), .Dout (dout_w[0]), .BUSY (busy_w[0]), .DONE (done_w[0])
  );

  pipo_univ_shreg #(.WIDTH(W), .STEP(2)) dut_s2 (
    .CLK (clk), .RST (rst), .LOAD (load), .START (start), .MODE (mode),
    .AMT (amt), .Din (din), .Dout (dout_w[1]), .BUSY (busy_w[1]), .DONE (done_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int step_of(input int s);
    return (s == 0) ? 1 : 2;
  endfunction

  // Whole-distance shift of an 8-bit value by n (0..7), from the mode rules
  function automatic logic [7:0] ref_op(input logic [1:0] md, input logic [7:0] v, input int n);
    int x;
    int r;
    x = v;
    case (md)
      2'b00: r = ((x >> n) | (x << (W - n))) & 255;
      2'b01: r = ((x << n) | (x >> (W - n))) & 255;
      2'b10: begin
`ifdef PIPO_ARITH_SHIFT_EN
        if (x >= 128) x = x - 256;
        r = (x >>> n) & 255;
`else
        r = x >> n;
`endif
      end
      default: r = (x << n) & 255;
    endcase
    return r[7:0];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_dout[s] = 8'h00;
      m_busy[s] = 1'b0;
      m_done[s] = 1'b0;
      m_mode[s] = 2'b00;
    end
  endtask

  // One rising edge of the model: each operation is tracked by its start value
  // and elapsed cycles, and Dout is the full shift by the distance covered so far
  task automatic model_edge();
    int moved;
    for (int s = 0; s < 2; s++) begin
      m_done[s] = 1'b0;
      if (load) begin
        m_dout[s] = din;
        m_busy[s] = 1'b0;
      end else if (!m_busy[s]) begin
        if (start) begin
          if (amt == 3'd0) begin
            m_done[s] = 1'b1;
          end else begin
            m_busy[s] = 1'b1;
            m_base[s] = m_dout[s];
            m_mode[s] = mode;
            m_amt[s]  = amt;
            m_el[s]   = 0;
          end
        end
      end else begin
        m_el[s]++;
        moved = m_el[s] * step_of(s);
        if (moved > m_amt[s]) moved = m_amt[s];
        m_dout[s] = ref_op(m_mode[s], m_base[s], moved);
        if (moved == m_amt[s]) begin
          m_busy[s] = 1'b0;
          m_done[s] = 1'b1;
        end
      end
    end
  endtask

  task automatic clear_counts();
    for (int s = 0; s < 2; s++) begin
      cnt_busy[s] = 0;
      cnt_done[s] = 0;
    end
  endtask

  // Apply inputs for one clock, advance the model, compare 1 time unit after the edge
  task automatic cycle(input logic ld, input logic st, input logic [1:0] md,
                       input logic [2:0] am, input logic [7:0] d);
    load = ld; start = st; mode = md; amt = am; din = d;
    @(posedge clk);
    model_edge();
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("dout_s%0d", step_of(s)), dout_w[s], m_dout[s]);
      chk($sformatf("busy_s%0d", step_of(s)), busy_w[s], m_busy[s]);
      chk($sformatf("done_s%0d", step_of(s)), done_w[s], m_done[s]);
      cnt_busy[s] += int'(busy_w[s]);
      cnt_done[s] += int'(done_w[s]);
    end
    if (ld || st)
      $display("t=%0t load=%0d start=%0d mode=%0d amt=%0d din=0x%02h -> s1 0x%02h s2 0x%02h",
               $time, ld, st, md, am, d, dout_w[0], dout_w[1]);
  endtask

  // Load, start, let it run out, then check final value and BUSY/DONE cycle counts
  task automatic run_op(input string name, input logic [7:0] d, input logic [1:0] md,
                        input logic [2:0] am, input logic [7:0] exp_final,
                        input int exp_b1, input int exp_b2);
    cycle(1'b1, 1'b0, 2'b00, 3'd0, d);
    clear_counts();
    cycle(1'b0, 1'b1, md, am, 8'h00);
    repeat (9) cycle(1'b0, 1'b0, 2'b00, 3'd0, 8'h00);
    chk({name, "_final_s1"}, dout_w[0], exp_final);
    chk({name, "_final_s2"}, dout_w[1], exp_final);
    chk({name, "_busycyc_s1"}, cnt_busy[0], exp_b1);
    chk({name, "_busycyc_s2"}, cnt_busy[1], exp_b2);
    chk({name, "_done_s1"}, cnt_done[0], 1);
    chk({name, "_done_s2"}, cnt_done[1], 1);
  endtask

  initial begin
    logic [7:0] shr_exp;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; load = 1'b0; start = 1'b0; mode = 2'b00; amt = 3'd0; din = 8'h00;
    model_reset();
    clear_counts();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_dout", dout_w[s], 8'h00);
      chk("rst_busy", busy_w[s], 1'b0);
      chk("rst_done", done_w[s], 1'b0);
    end
    #2 rst = 1'b0;

    // directed operations
    run_op("ror", 8'hB1, 2'b00, 3'd3, 8'h36, 3, 2);
    run_op("rol", 8'h81, 2'b01, 3'd1, 8'h03, 1, 1);
`ifdef PIPO_ARITH_SHIFT_EN
    shr_exp = 8'hFF;
`else
    shr_exp = 8'h0F;
`endif
    run_op("shr", 8'hF0, 2'b10, 3'd4, shr_exp, 4, 2);
    run_op("shl", 8'h01, 2'b11, 3'd5, 8'h20, 5, 3);
    run_op("amt0", 8'h5A, 2'b01, 3'd0, 8'h5A, 0, 0);

    // STEP=2 intermediate values of the multi-step left shift
    cycle(1'b1, 1'b0, 2'b00, 3'd0, 8'h01);
    cycle(1'b0, 1'b1, 2'b11, 3'd5, 8'h00);
    cycle(1'b0, 1'b0, 2'b00, 3'd0, 8'h00);
    chk("ms_step1", dout_w[1], 8'h04);
    cycle(1'b0, 1'b0, 2'b00, 3'd0, 8'h00);
    chk("ms_step2", dout_w[1], 8'h10);
    cycle(1'b0, 1'b0, 2'b00, 3'd0, 8'h00);
    chk("ms_step3", dout_w[1], 8'h20);
    chk("ms_done", done_w[1], 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 2'b00, 3'd0, 8'h00);

    // LOAD in the second RUN cycle aborts without DONE
    cycle(1'b1, 1'b0, 2'b00, 3'd0, 8'h0F);
    clear_counts();
    cycle(1'b0, 1'b1, 2'b01, 3'd6, 8'h00);
    cycle(1'b0, 1'b0, 2'b00, 3'd0, 8'h00);
    cycle(1'b1, 1'b0, 2'b00, 3'd0, 8'h55);
    repeat (8) cycle(1'b0, 1'b0, 2'b00, 3'd0, 8'h00);
    for (int s = 0; s < 2; s++) begin
      chk("abort_dout", dout_w[s], 8'h55);
      chk("abort_busy", busy_w[s], 1'b0);
      chk("abort_done", cnt_done[s], 0);
    end

    // RST in the middle of an operation clears Dout before any clock edge
    cycle(1'b1, 1'b0, 2'b00, 3'd0, 8'hA5);
    cycle(1'b0, 1'b1, 2'b00, 3'd6, 8'h00);
    cycle(1'b0, 1'b0, 2'b00, 3'd0, 8'h00);
    #2 rst = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("midrst_dout", dout_w[s], 8'h00);
      chk("midrst_busy", busy_w[s], 1'b0);
    end
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    clear_counts();
    repeat (8) cycle(1'b0, 1'b0, 2'b00, 3'd0, 8'h00);
    for (int s = 0; s < 2; s++) begin
      chk("postrst_done", cnt_done[s], 0);
      chk("postrst_dout", dout_w[s], 8'h00);
    end

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 11) == 0), ($urandom_range(0, 2) == 0),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
